// File: rtl/aha_tlx_pkg.sv
// Shared types and constants for the TLX RX lane training monitor.
package aha_tlx_pkg;

  localparam int unsigned TLX_WORD_W    = 32;
  localparam int unsigned TLX_ERR_CNT_W = 16;
  localparam int unsigned TLX_BIT_CNT_W = 5;

  // Monitor FSM encoding
  typedef logic [1:0] tlx_state_t;
  localparam tlx_state_t ST_IDLE   = 2'b00;
  localparam tlx_state_t ST_SEARCH = 2'b01;
  localparam tlx_state_t ST_LOCKED = 2'b10;
  localparam tlx_state_t ST_FINISH = 2'b11;

  // Number of set bits in a training-word-sized vector (0..32)
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/aha_tlx_edge_detect.sv
// Rising-edge detector: one-cycle registered pulse the cycle after D rises.
module aha_tlx_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic RISE_PULSE
);

  logic d_q, d_d;
  logic pulse_q, pulse_d;

  // Remember last level and flag a low-to-high transition
  always_comb begin
    d_d     = D;
    pulse_d = D & ~d_q;
  end

  // Detector state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      d_q     <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      pulse_q <= pulse_d;
    end
  end

  assign RISE_PULSE = pulse_q;

endmodule

// File: rtl/aha_tlx_training_monitor.sv
// TLX RX lane training monitor: deserialises one bit per clock (LSB first),
// hunts for the training word, holds word alignment and counts good/bad words.
// Optional feature macro: TLX_RX_BIT_ERR_CNT_EN adds BIT_ERR_COUNT (bit-error tally).
module aha_tlx_training_monitor
  import aha_tlx_pkg::*;
#(
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        D_IN,
  input  logic        START,
  input  logic        CLEAR,
  input  logic [31:0] SEQUENCE,
  input  logic [31:0] LENGTH,
  input  logic        AUTO_STOP,
  output logic        LOCKED,
  output logic        DONE,
  output logic        LOCK_LOST,
  output logic        ACTIVE,
  output logic [31:0] MATCH_COUNT,
  output logic [15:0] ERR_COUNT
`ifdef TLX_RX_BIT_ERR_CNT_EN
  ,
  output logic [31:0] BIT_ERR_COUNT
`endif
);

  logic start_pulse;
  logic clear_pulse;

  aha_tlx_edge_detect u_start_edge (
    .CLK        (CLK),
    .RESET      (RESET),
    .D          (START),
    .RISE_PULSE (start_pulse)
  );

  aha_tlx_edge_detect u_clear_edge (
    .CLK        (CLK),
    .RESET      (RESET),
    .D          (CLEAR),
    .RISE_PULSE (clear_pulse)
  );

  // Only the upper 31 bits of the shift register are ever read back, so just those are kept
  logic [TLX_WORD_W-2:0]    hist_q, hist_d;
  logic [TLX_WORD_W-1:0]    sr_nxt;
  tlx_state_t               state_q, state_d;
  logic [TLX_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]               miss_cnt_q, miss_cnt_d;
  logic [TLX_WORD_W-1:0]    match_cnt_q, match_cnt_d;
  logic [TLX_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                     done_q, done_d;
  logic                     lost_q, lost_d;
  logic                     word_ok;
  logic                     strobe;
  logic [TLX_WORD_W-1:0]    match_inc;
  logic [3:0]               miss_inc;

`ifdef TLX_RX_BIT_ERR_CNT_EN
  logic [31:0] bit_err_q, bit_err_d;
  logic [32:0] bit_err_sum;
`endif

  // Next-state, counter and status update
  always_comb begin
    hist_d      = sr_nxt[TLX_WORD_W-1:1];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    done_d      = done_q;
    lost_d      = lost_q;
    sr_nxt      = {D_IN, hist_q};
    word_ok     = (sr_nxt == SEQUENCE);
    strobe      = (bit_cnt_q == 5'd31);
    match_inc   = match_cnt_q + 32'd1;
    miss_inc    = miss_cnt_q + 4'd1;
`ifdef TLX_RX_BIT_ERR_CNT_EN
    bit_err_d   = bit_err_q;
    bit_err_sum = {1'b0, bit_err_q} + 33'(popcount32(sr_nxt ^ SEQUENCE));
`endif

    if (clear_pulse) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      miss_cnt_d  = '0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      done_d      = 1'b0;
      lost_d      = 1'b0;
`ifdef TLX_RX_BIT_ERR_CNT_EN
      bit_err_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_d     = ST_SEARCH;
            bit_cnt_d   = '0;
            miss_cnt_d  = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            done_d      = 1'b0;
            lost_d      = 1'b0;
`ifdef TLX_RX_BIT_ERR_CNT_EN
            bit_err_d   = '0;
`endif
          end
        end
        ST_SEARCH: begin
          // Any bit position may be a word boundary; the first full match locks it in
          if (word_ok) begin
            state_d     = ST_LOCKED;
            match_cnt_d = match_inc;
            bit_cnt_d   = '0;
            miss_cnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (strobe) begin
            if (word_ok) begin
              match_cnt_d = match_inc;
              miss_cnt_d  = '0;
              if (AUTO_STOP && (match_inc == LENGTH)) begin
                state_d = ST_FINISH;
                done_d  = 1'b1;
              end
            end else begin
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
              end
`ifdef TLX_RX_BIT_ERR_CNT_EN
              bit_err_d = bit_err_sum[32] ? 32'hFFFF_FFFF : bit_err_sum[31:0];
`endif
              if (miss_inc == 4'(LOSS_THRESH)) begin
                state_d    = ST_SEARCH;
                lost_d     = 1'b1;
                miss_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_inc;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hist_q      <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
      lost_q      <= 1'b0;
`ifdef TLX_RX_BIT_ERR_CNT_EN
      bit_err_q   <= '0;
`endif
    end else begin
      hist_q      <= hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
      lost_q      <= lost_d;
`ifdef TLX_RX_BIT_ERR_CNT_EN
      bit_err_q   <= bit_err_d;
`endif
    end
  end

  assign LOCKED      = (state_q == ST_LOCKED);
  assign ACTIVE      = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
  assign DONE        = done_q;
  assign LOCK_LOST   = lost_q;
  assign MATCH_COUNT = match_cnt_q;
  assign ERR_COUNT   = err_cnt_q;
`ifdef TLX_RX_BIT_ERR_CNT_EN
  assign BIT_ERR_COUNT = bit_err_q;
`endif

endmodule

// File: tb/tb_aha_tlx_training_monitor.sv
// Directed bench for aha_tlx_training_monitor (default LOSS_THRESH = 4).
// Builds with or without TLX_RX_BIT_ERR_CNT_EN.
module tb_aha_tlx_training_monitor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        D_IN;
  logic        START;
  logic        CLEAR;
  logic [31:0] SEQUENCE;
  logic [31:0] LENGTH;
  logic        AUTO_STOP;
  logic        LOCKED;
  logic        DONE;
  logic        LOCK_LOST;
  logic        ACTIVE;
  logic [31:0] MATCH_COUNT;
  logic [15:0] ERR_COUNT;
`ifdef TLX_RX_BIT_ERR_CNT_EN
  logic [31:0] BIT_ERR_COUNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] SEQ  = 32'hA5A5_3C3C;
  localparam logic [31:0] BAD1 = SEQ ^ 32'h0000_0020;
  localparam logic [31:0] BAD2 = SEQ ^ 32'h0001_0002;

  aha_tlx_training_monitor dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .D_IN        (D_IN),
    .START       (START),
    .CLEAR       (CLEAR),
    .SEQUENCE    (SEQUENCE),
    .LENGTH      (LENGTH),
    .AUTO_STOP   (AUTO_STOP),
    .LOCKED      (LOCKED),
    .DONE        (DONE),
    .LOCK_LOST   (LOCK_LOST),
    .ACTIVE      (ACTIVE),
    .MATCH_COUNT (MATCH_COUNT),
    .ERR_COUNT   (ERR_COUNT)
`ifdef TLX_RX_BIT_ERR_CNT_EN
    ,
    .BIT_ERR_COUNT (BIT_ERR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick(input logic b);
    D_IN = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) tick(w[i]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    START = 1'b1;
    tick(1'b0);
    tick(1'b0);
    START = 1'b0;
  endtask

  task automatic clear_run();
    CLEAR = 1'b1;
    tick(1'b0);
    tick(1'b0);
    CLEAR = 1'b0;
    tick(1'b0);
  endtask

  initial begin
    RESET = 1'b1; D_IN = 1'b0; START = 1'b0; CLEAR = 1'b0;
    SEQUENCE = SEQ; LENGTH = 32'd8; AUTO_STOP = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_active", 32'(ACTIVE), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_lost", 32'(LOCK_LOST), 32'd0);
    chk("rst_match", MATCH_COUNT, 32'd0);
    chk("rst_err", 32'(ERR_COUNT), 32'd0);
    RESET = 1'b0;
    tick(1'b0);

    // 1: lock on first word, finish after 8 matches
    start_run();
    chk("t1_search_active", 32'(ACTIVE), 32'd1);
    chk("t1_search_locked", 32'(LOCKED), 32'd0);
    tick(1'b1); tick(1'b1); tick(1'b0);
    send_word(SEQ);
    chk("t1_lock", 32'(LOCKED), 32'd1);
    chk("t1_lock_match", MATCH_COUNT, 32'd1);
    for (int w = 0; w < 6; w++) send_word(SEQ);
    chk("t1_match7", MATCH_COUNT, 32'd7);
    chk("t1_done_early", 32'(DONE), 32'd0);
    send_word(SEQ);
    chk("t1_done", 32'(DONE), 32'd1);
    chk("t1_match8", MATCH_COUNT, 32'd8);
    chk("t1_err", 32'(ERR_COUNT), 32'd0);
    chk("t1_active_fall", 32'(ACTIVE), 32'd0);
    chk("t1_unlocked", 32'(LOCKED), 32'd0);
    tick(1'b0);
    chk("t1_done_sticky", 32'(DONE), 32'd1);

    // 2: four consecutive bad words drop lock, relock keeps counting
    START = 1'b1;
    tick(1'b0);
    chk("t2_done_hold", 32'(DONE), 32'd1);
    tick(1'b0);
    START = 1'b0;
    chk("t2_done_clr", 32'(DONE), 32'd0);
    chk("t2_match_clr", MATCH_COUNT, 32'd0);
    chk("t2_active", 32'(ACTIVE), 32'd1);
    for (int w = 0; w < 3; w++) send_word(SEQ);
    chk("t2_match3", MATCH_COUNT, 32'd3);
    for (int w = 0; w < 3; w++) send_word(BAD1);
    chk("t2_err3", 32'(ERR_COUNT), 32'd3);
    chk("t2_still_locked", 32'(LOCKED), 32'd1);
    send_word(BAD1);
    chk("t2_err4", 32'(ERR_COUNT), 32'd4);
    chk("t2_lost", 32'(LOCK_LOST), 32'd1);
    chk("t2_unlocked", 32'(LOCKED), 32'd0);
    chk("t2_search", 32'(ACTIVE), 32'd1);
    chk("t2_match_kept", MATCH_COUNT, 32'd3);
    send_word(SEQ);
    chk("t2_relock", 32'(LOCKED), 32'd1);
    chk("t2_match4", MATCH_COUNT, 32'd4);
    chk("t2_lost_sticky", 32'(LOCK_LOST), 32'd1);

    // 3: three bad then one good never loses lock
    for (int w = 0; w < 3; w++) send_word(BAD1);
    send_word(SEQ);
    chk("t3_err7", 32'(ERR_COUNT), 32'd7);
    chk("t3_match5", MATCH_COUNT, 32'd5);
    for (int w = 0; w < 3; w++) send_word(BAD1);
    send_word(SEQ);
    chk("t3_err10", 32'(ERR_COUNT), 32'd10);
    chk("t3_match6", MATCH_COUNT, 32'd6);
    chk("t3_locked", 32'(LOCKED), 32'd1);
    clear_run();
    chk("t3_clr_locked", 32'(LOCKED), 32'd0);
    chk("t3_clr_active", 32'(ACTIVE), 32'd0);
    chk("t3_clr_match", MATCH_COUNT, 32'd0);
    chk("t3_clr_err", 32'(ERR_COUNT), 32'd0);
    chk("t3_clr_lost", 32'(LOCK_LOST), 32'd0);

    // 4: free-running past LENGTH, then CLEAR
    AUTO_STOP = 1'b0;
    start_run();
    for (int w = 0; w < 100; w++) send_word(SEQ);
    chk("t4_match100", MATCH_COUNT, 32'd100);
    chk("t4_locked", 32'(LOCKED), 32'd1);
    chk("t4_done", 32'(DONE), 32'd0);
    CLEAR = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("t4_clr_locked", 32'(LOCKED), 32'd0);
    chk("t4_clr_match", MATCH_COUNT, 32'd0);
    chk("t4_clr_done", 32'(DONE), 32'd0);
    chk("t4_clr_active", 32'(ACTIVE), 32'd0);

    // 5a: CLEAR and START together from IDLE stay IDLE
    CLEAR = 1'b0; START = 1'b0;
    tick(1'b0);
    CLEAR = 1'b1; START = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("t5_both_idle", 32'(ACTIVE), 32'd0);
    tick(1'b0);
    chk("t5_both_idle2", 32'(ACTIVE), 32'd0);
    CLEAR = 1'b0; START = 1'b0;
    tick(1'b0);

    // LENGTH==0 with AUTO_STOP: never finishes
    AUTO_STOP = 1'b1; LENGTH = 32'd0;
    start_run();
    for (int w = 0; w < 3; w++) send_word(SEQ);
    chk("len0_match", MATCH_COUNT, 32'd3);
    chk("len0_done", 32'(DONE), 32'd0);
    chk("len0_locked", 32'(LOCKED), 32'd1);
    clear_run();

`ifdef TLX_RX_BIT_ERR_CNT_EN
    // 6: five two-bit-error words, lock held by a clean word in between
    AUTO_STOP = 1'b0;
    start_run();
    send_word(SEQ);
    for (int w = 0; w < 3; w++) send_word(BAD2);
    send_word(SEQ);
    for (int w = 0; w < 2; w++) send_word(BAD2);
    chk("t6_bit_err", BIT_ERR_COUNT, 32'd10);
    chk("t6_err", 32'(ERR_COUNT), 32'd5);
    chk("t6_locked", 32'(LOCKED), 32'd1);
    clear_run();
    chk("t6_clr_bit_err", BIT_ERR_COUNT, 32'd0);
`endif

    // 5b: RESET while LOCKED returns everything to zero immediately
    AUTO_STOP = 1'b1; LENGTH = 32'd8;
    start_run();
    send_word(SEQ);
    send_word(BAD1);
    chk("t5_pre_locked", 32'(LOCKED), 32'd1);
    chk("t5_pre_err", 32'(ERR_COUNT), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_rst_locked", 32'(LOCKED), 32'd0);
    chk("t5_rst_active", 32'(ACTIVE), 32'd0);
    chk("t5_rst_match", MATCH_COUNT, 32'd0);
    chk("t5_rst_err", 32'(ERR_COUNT), 32'd0);
    chk("t5_rst_done", 32'(DONE), 32'd0);
    chk("t5_rst_lost", 32'(LOCK_LOST), 32'd0);
    tick(1'b0);
    RESET = 1'b0;
    tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
